// File: rtl/pipeline_wb_trace.sv
// -----------------------------------------------------------------------------
// pipeline_wb_trace
//
// Write-back trace collector. Snoops the register-file write port of the
// pipeline and records every retired register write (destination, data and,
// optionally, a cycle timestamp) into a show-ahead FIFO that a debug host
// drains through a valid/pop handshake. Capture never back-pressures the
// pipeline: when the FIFO is full and nothing is popped, the write is dropped
// and the sticky overflow flag is raised.
//
// Optional feature macro: WB_TRACE_TS_EN
//   Adds a free-running TS_W-bit cycle counter, per-entry timestamp storage
//   and the rd_ts output port.
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high
//   wb_en     : write-back stage writes the register file this cycle
//   wb_rd     : destination register index
//   wb_data   : value being written
//   halt      : freeze capture (draining still works)
//   rd_en     : pop the head entry
//   rd_valid  : FIFO non-empty
//   rd_rd     : head entry destination index (don't-care when !rd_valid)
//   rd_data   : head entry data (don't-care when !rd_valid)
//   rd_ts     : head entry timestamp (WB_TRACE_TS_EN only)
//   count     : occupancy, 0..DEPTH
//   overflow  : sticky, a capture was dropped on a full FIFO
//   retired   : number of accepted entries, modulo 2^16
// -----------------------------------------------------------------------------
module pipeline_wb_trace #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_rd,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    halt,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [ADDR_W-1:0]       rd_rd,
  output logic [DATA_W-1:0]       rd_data,
`ifdef WB_TRACE_TS_EN
  output logic [TS_W-1:0]         rd_ts,
`endif
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [15:0]             retired
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic capture;
  logic full;
  logic pop;
  logic push;

  // Register 0 is hard-wired; writes to it never retire architecturally.
  assign capture  = wb_en && !halt && (wb_rd != '0);
  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_en && rd_valid;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push     = capture && (!full || pop);

  // Show-ahead head: combinational read of registered pointer and storage only.
  assign rd_rd   = rd_mem[rd_ptr];
  assign rd_data = data_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      retired  <= '0;
    end else begin
      // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (push)             retired  <= retired + 16'd1;
      if (capture && !push) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count define
  // which slots hold live data, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      rd_mem[wr_ptr]   <= wb_rd;
      data_mem[wr_ptr] <= wb_data;
    end
  end

`ifdef WB_TRACE_TS_EN
  logic [TS_W-1:0] cycle_cnt;
  logic [TS_W-1:0] ts_mem [DEPTH];

  // Free-running: keeps counting through halt so timestamps stay in real time.
  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !reset) ts_mem[wr_ptr] <= cycle_cnt;
  end

  assign rd_ts = ts_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_pipeline_wb_trace.sv
// -----------------------------------------------------------------------------
// tb_pipeline_wb_trace
//
// Scoreboard bench for pipeline_wb_trace. The driver applies inputs one cycle
// at a time and, at each rising edge, updates a queue-based reference model
// (accepted entries, occupancy, overflow, retired, cycle counter). A separate
// monitor samples the DUT on the falling edge, compares the status outputs
// with the model and pops/compares the head entry whenever a pop is issued.
// -----------------------------------------------------------------------------
module tb_pipeline_wb_trace;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              halt;
  logic              rd_en;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_rd;
  logic [DATA_W-1:0] rd_data;
`ifdef WB_TRACE_TS_EN
  logic [TS_W-1:0]   rd_ts;
`endif
  logic [$clog2(DEPTH):0] count;
  logic              overflow;
  logic [15:0]       retired;

  pipeline_wb_trace #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .halt     (halt),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_rd    (rd_rd),
    .rd_data  (rd_data),
`ifdef WB_TRACE_TS_EN
    .rd_ts    (rd_ts),
`endif
    .count    (count),
    .overflow (overflow),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;

  // Reference model state
  entry_t      sb[$];
  int          m_count = 0;
  bit          m_ovf   = 1'b0;
  int          m_ret   = 0;
  logic [15:0] m_cyc   = '0;
  bit          mon_en  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the block must do at one rising edge, given the applied inputs.
  task automatic model_edge();
    bit cap, pop;
    if (reset) begin
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_ret   = 0;
      m_cyc   = '0;
    end else begin
      cap = wb_en && !halt && (wb_rd != 0);
      pop = rd_en && (m_count > 0);
      if (cap && (m_count < DEPTH || pop)) begin
        entry_t e;
        e.rd = wb_rd; e.data = wb_data; e.ts = m_cyc;
        sb.push_back(e);
        m_count++;
        m_ret = (m_ret + 1) % 65536;
      end else if (cap) begin
        m_ovf = 1'b1;
      end
      if (pop) m_count--;
      m_cyc = m_cyc + 16'd1;
    end
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the edge.
  task automatic step(input logic r, input logic en, input logic [ADDR_W-1:0] rdi,
                      input logic [DATA_W-1:0] d, input logic h, input logic re);
    reset = r; wb_en = en; wb_rd = rdi; wb_data = d; halt = h; rd_en = re;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(); step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0); endtask
  task automatic do_reset(); step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0); endtask
  task automatic wr(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    step(1'b0, 1'b1, r, d, 1'b0, 1'b0);
  endtask
  task automatic pop_chk(input logic [DATA_W-1:0] d);
    check("drain_head_data", {24'd0, rd_data}, {24'd0, d});
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: status vs model every cycle, head vs scoreboard on each pop.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        check("count", 32'(count), m_count);
        check("rd_valid", 32'(rd_valid), 32'(m_count != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("retired", 32'(retired), m_ret);
        if (rd_valid && rd_en) begin
          if (sb.size() > 0) begin
            entry_t e;
            e = sb.pop_front();
            check("pop_rd", 32'(rd_rd), 32'(e.rd));
            check("pop_data", 32'(rd_data), 32'(e.data));
`ifdef WB_TRACE_TS_EN
            check("pop_ts", 32'(rd_ts), 32'(e.ts));
`endif
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: DUT valid with rd_data 0x%0h, scoreboard empty", rd_data);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0; halt = 1'b0; rd_en = 1'b0;

    // Reset then idle
    do_reset();
    mon_en = 1'b1;
    do_reset();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_retired", 32'(retired), 0);

    // Filtering: register 0 and halted writes are not traced
    wr(3'd0, 8'hAA);
    step(1'b0, 1'b1, 3'd2, 8'hBB, 1'b1, 1'b0);
    check("filter_count", 32'(count), 0);
    check("filter_retired", 32'(retired), 0);

    // Single capture / drain
    wr(3'd3, 8'h5A);
    check("single_valid", 32'(rd_valid), 1);
    check("single_rd", 32'(rd_rd), 3);
    check("single_data", 32'(rd_data), 32'h5A);
    check("single_count", 32'(count), 1);
    check("single_retired", 32'(retired), 1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("single_valid_after_pop", 32'(rd_valid), 0);
    check("single_count_after_pop", 32'(count), 0);
    // Pop while empty is ignored
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("empty_pop_count", 32'(count), 0);

    // Overflow and wrap
    do_reset();
    for (int i = 0; i < 9; i++)
      wr((i < 7) ? 3'(i + 1) : 3'(i - 6), 8'(8'h10 + i));
    check("ovf_count", 32'(count), 8);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_retired", 32'(retired), 8);
    for (int i = 0; i < 8; i++) pop_chk(8'(8'h10 + i));
    check("ovf_drained", 32'(count), 0);
    check("ovf_sticky", 32'(overflow), 1);
    for (int i = 0; i < 3; i++) wr(3'(i + 4), 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) pop_chk(8'(8'h20 + i));

    // Simultaneous push/pop at full: no drop, new entry goes last
    do_reset();
    for (int i = 0; i < 8; i++) wr(3'(i % 7 + 1), 8'(8'h30 + i));
    step(1'b0, 1'b1, 3'd5, 8'h99, 1'b0, 1'b1);
    check("full_pushpop_count", 32'(count), 8);
    check("full_pushpop_ovf", 32'(overflow), 0);
    check("full_pushpop_retired", 32'(retired), 9);
    for (int i = 1; i < 8; i++) pop_chk(8'(8'h30 + i));
    pop_chk(8'h99);

    // Timestamps: reset released at cycle 0, captures at cycles 5 and 9
    do_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c == 5)      wr(3'd1, 8'h55);
      else if (c == 9) wr(3'd2, 8'h99);
      else             idle();
    end
`ifdef WB_TRACE_TS_EN
    check("ts_first", 32'(rd_ts), 5);
`endif
    pop_chk(8'h55);
`ifdef WB_TRACE_TS_EN
    check("ts_second", 32'(rd_ts), 9);
`endif
    pop_chk(8'h99);

    // Reset on a push cycle discards everything, push ignored
    for (int i = 0; i < 3; i++) wr(3'd6, 8'(8'h60 + i));
    check("preload_count", 32'(count), 3);
    step(1'b1, 1'b1, 3'd7, 8'h77, 1'b0, 1'b1);
    check("rst_push_count", 32'(count), 0);
    check("rst_push_retired", 32'(retired), 0);
    check("rst_push_valid", 32'(rd_valid), 0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           3'($urandom_range(0, 7)),
           8'($urandom),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 4));
    end
    // Drain whatever is left so every accepted entry reaches the monitor
    for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("final_count", 32'(count), 0);
    check("final_sb_empty", 32'(sb.size()), 0);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
